// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and
// an optional 2-entry skid buffer that makes in_ready a flop.
module pipe_skid_stage #(
  parameter int               WIDTH      = 143,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             main_vld_p0;
  logic             skid_vld_p0;
  logic [WIDTH-1:0] main_data_p0;
  logic [WIDTH-1:0] skid_data_p0;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  // Valid bits are a decode of the state register, so main is always the older entry.
  assign main_vld_p0 = (state != EMPTY);
  assign skid_vld_p0 = (state == FULL);

  assign out_valid = main_vld_p0;
  assign out_data  = main_vld_p0 ? main_data_p0 : BUBBLE_VAL;
  assign occupancy = {1'b0, main_vld_p0} + {1'b0, skid_vld_p0};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_vld_p0 & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_nxt != FULL);
        end
      end

      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign in_ready = out_ready | ~main_vld_p0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt    = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            // Without a skid entry in_fire implies out_fire here, so FULL is never entered.
            if (SKID != 0) begin
              state_nxt = FULL;
              load_skid = 1'b1;
            end
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt      = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage p0 data registers: only written on a fire, so a stalled payload stays bit-stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data_p0 <= BUBBLE_VAL;
      skid_data_p0 <= BUBBLE_VAL;
    end else begin
      if (load_main_in) begin
        main_data_p0 <= in_data;
      end else if (load_main_skid) begin
        main_data_p0 <= skid_data_p0;
      end
      if (load_skid) begin
        skid_data_p0 <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three configurations driven side by side and
// compared every cycle against a FIFO-of-entries reference model.
module tb_pipe_skid_stage;
  localparam int W = 143;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid  [N];
  logic         in_ready  [N];
  logic [W-1:0] in_data   [N];
  logic         out_valid [N];
  logic         out_ready [N];
  logic [W-1:0] out_data  [N];
  logic [1:0]   occupancy [N];

  // Reference model: entries held, oldest at index 0, bounded by capacity.
  int           cap [N];
  logic [W-1:0] bub [N];
  logic [W-1:0] mem [N][2];
  int           cnt [N];
  logic         fired [N];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(W), .SKID(1), .BUBBLE_VAL('0)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occupancy[0])
  );

  pipe_skid_stage #(.WIDTH(W), .SKID(0), .BUBBLE_VAL('0)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occupancy[1])
  );

  pipe_skid_stage #(.WIDTH(W), .SKID(1), .BUBBLE_VAL(143'h5)) u_bub (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .occupancy(occupancy[2])
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int i);
    if (cap[i] == 2) return (cnt[i] < 2);
    return out_ready[i] || (cnt[i] == 0);
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = v;
      in_data[i]   = d;
      out_ready[i] = r;
    end
    flush = f;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic cycle();
    logic fire_in  [N];
    logic fire_out [N];
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("out_valid[%0d]", i), W'(out_valid[i]), W'(cnt[i] > 0));
      check($sformatf("out_data[%0d]", i), out_data[i], (cnt[i] > 0) ? mem[i][0] : bub[i]);
      check($sformatf("occupancy[%0d]", i), W'(occupancy[i]), W'(cnt[i]));
      check($sformatf("in_ready[%0d]", i), W'(in_ready[i]), W'(exp_ready(i)));
      fire_in[i]  = in_valid[i] && exp_ready(i);
      fire_out[i] = (cnt[i] > 0) && out_ready[i];
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (flush) begin
        cnt[i] = 0;
      end else begin
        if (fire_out[i]) begin
          mem[i][0] = mem[i][1];
          cnt[i]--;
        end
        if (fire_in[i]) begin
          mem[i][cnt[i]] = in_data[i];
          cnt[i]++;
        end
      end
      fired[i] = fire_in[i];
    end
    #1;
  endtask

  initial begin
    cap[0] = 2; cap[1] = 1; cap[2] = 2;
    bub[0] = '0; bub[1] = '0; bub[2] = W'(5);
    for (int i = 0; i < N; i++) begin
      cnt[i]   = 0;
      fired[i] = 1'b0;
      mem[i][0] = '0;
      mem[i][1] = '0;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", W'(out_valid[0]), W'(0));
    check("rst_bubble5", out_data[2], W'(5));
    check("rst_in_ready_skid", W'(in_ready[0]), W'(1));
    check("rst_in_ready_noskid", W'(in_ready[1]), W'(1));
    cycle();

    // Streaming 1..8 with no backpressure: one-cycle lag, no gaps.
    for (int k = 1; k <= 9; k++) begin
      drive(k <= 8, W'(k), 1'b1, 1'b0);
      cycle();
      if (k <= 8) begin
        check("stream_skid", out_data[0], W'(k));
        check("stream_noskid", out_data[1], W'(k));
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    cycle();

    // Backpressure fills the skid entry, then drains in order.
    drive(1'b1, W'('hA), 1'b0, 1'b0); cycle();
    drive(1'b1, W'('hB), 1'b0, 1'b0); cycle();
    drive(1'b1, W'('hC), 1'b0, 1'b0); cycle();
    check("full_occ", W'(occupancy[0]), W'(2));
    check("full_in_ready", W'(in_ready[0]), W'(0));
    check("full_head", out_data[0], W'('hA));
    drive(1'b1, W'('hC), 1'b1, 1'b0); cycle();
    check("drain_b", out_data[0], W'('hB));
    drive(1'b1, W'('hC), 1'b1, 1'b0); cycle();
    check("drain_c", out_data[0], W'('hC));
    drive(1'b0, '0, 1'b1, 1'b0); cycle();
    check("drain_empty", W'(out_valid[0]), W'(0));
    drive(1'b0, '0, 1'b1, 1'b0); cycle();

    // Flush while full with a payload offered.
    drive(1'b1, W'('h11), 1'b0, 1'b0); cycle();
    drive(1'b1, W'('h12), 1'b0, 1'b0); cycle();
    check("pre_flush_occ", W'(occupancy[0]), W'(2));
    drive(1'b1, W'('hD), 1'b0, 1'b1); cycle();
    check("flush_occ", W'(occupancy[0]), W'(0));
    check("flush_valid", W'(out_valid[0]), W'(0));
    check("flush_bubble0", out_data[0], W'(0));
    check("flush_bubble5", out_data[2], W'(5));
    drive(1'b0, '0, 1'b1, 1'b0); cycle();
    check("flush_d_dropped", W'(out_valid[0]), W'(0));

    // Single-entry configuration: combinational ready and pass-through.
    drive(1'b1, W'('h21), 1'b0, 1'b0); cycle();
    drive(1'b1, W'('h22), 1'b0, 1'b0);
    #1 check("noskid_stall_ready", W'(in_ready[1]), W'(0));
    cycle();
    drive(1'b1, W'('h22), 1'b1, 1'b0);
    #1 check("noskid_release_ready", W'(in_ready[1]), W'(1));
    cycle();
    check("noskid_pass_22", out_data[1], W'('h22));
    check("noskid_occ", W'(occupancy[1]), W'(1));
    drive(1'b1, W'('h23), 1'b1, 1'b0); cycle();
    check("noskid_pass_23", out_data[1], W'('h23));
    check("noskid_occ2", W'(occupancy[1]), W'(1));
    repeat (3) begin
      drive(1'b0, '0, 1'b1, 1'b0); cycle();
    end

    // Asynchronous reset while two entries are held.
    drive(1'b1, W'('h31), 1'b0, 1'b0); cycle();
    drive(1'b1, W'('h32), 1'b0, 1'b0); cycle();
    check("pre_rst_occ", W'(occupancy[0]), W'(2));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", W'(out_valid[0]), W'(0));
    check("arst_data", out_data[0], W'(0));
    check("arst_occ", W'(occupancy[0]), W'(0));
    check("arst_bubble5", out_data[2], W'(5));
    for (int i = 0; i < N; i++) begin
      cnt[i]   = 0;
      fired[i] = 1'b0;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("arst_in_ready", W'(in_ready[0]), W'(1));
    cycle();

    // Randomised traffic with stable-until-accepted upstream and occasional flush.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(in_valid[i] && !fired[i])) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          in_data[i]  = rnd();
        end
        out_ready[i] = ($urandom_range(0, 2) != 0);
      end
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
